// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants and loader state type for the program-loader path.
package riscv_pkg;

  localparam logic [2:0] FMT_I  = 3'b000;
  localparam logic [2:0] FMT_S  = 3'b001;
  localparam logic [2:0] FMT_SB = 3'b010;
  localparam logic [2:0] FMT_U  = 3'b011;
  localparam logic [2:0] FMT_R  = 3'b100;
  localparam logic [2:0] FMT_UJ = 3'b101;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDrain,
    StDone
  } loader_state_e;

endpackage

// File: rtl/instr_encoder.sv
// Combinational packer: decoded fields plus format code -> 32-bit RV32I word and legality flag.
module instr_encoder
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    unique case (fmt)
      FMT_I:  word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_SB: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:  word = {imm[31:12], rd, opcode};
      FMT_R:  word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_UJ: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Stream-to-imem program loader: encodes field bundles and writes them to consecutive word addresses.
module instr_encode_loader
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            fmt,
  input  logic [6:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic                  last,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH-1:0] TopAddr = '1;

  loader_state_e         state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           enc_word;
  logic                  enc_legal;

  instr_encoder u_encoder (
    .fmt    (fmt),
    .opcode (opcode),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .funct3 (funct3),
    .funct7 (funct7),
    .imm    (imm[31:0]),
    .word   (enc_word),
    .legal  (enc_legal)
  );

  assign in_ready = (state_q == StLoad);
  assign busy     = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      count      <= '0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StLoad;
            addr_q  <= base_addr;
            count   <= '0;
            error   <= 1'b0;
          end
        end
        StLoad: begin
          if (in_valid) begin
            if (enc_legal) begin
              imem_we    <= 1'b1;
              imem_addr  <= addr_q;
              imem_wdata <= enc_word;
              count      <= count + 1'b1;
              // Hold at the top address; that write terminates the load instead of wrapping.
              if (addr_q != TopAddr) addr_q <= addr_q + 1'b1;
            end else begin
              error <= 1'b1;
            end
            if (last || (enc_legal && addr_q == TopAddr)) state_q <= StDrain;
          end
        end
        StDrain: begin
          state_q <= StDone;
          done    <= 1'b1;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed self-checking bench for instr_encode_loader (default and 4-bit address instances).
module tb_instr_encode_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start_s;
  logic [9:0]  base_addr;
  logic [3:0]  base_addr_s;
  logic        in_valid, in_valid_s;
  logic        in_ready, in_ready_s;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        last;
  logic        imem_we, imem_we_s;
  logic [9:0]  imem_addr;
  logic [3:0]  imem_addr_s;
  logic [31:0] imem_wdata, imem_wdata_s;
  logic        busy, busy_s, done, done_s, error, error_s;
  logic [10:0] count;
  logic [4:0]  count_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_encode_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .last(last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .error(error), .count(count)
  );

  instr_encode_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .base_addr(base_addr_s),
    .in_valid(in_valid_s), .in_ready(in_ready_s), .fmt(fmt), .opcode(opcode),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .last(last), .imem_we(imem_we_s), .imem_addr(imem_addr_s), .imem_wdata(imem_wdata_s),
    .busy(busy_s), .done(done_s), .error(error_s), .count(count_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bundle(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im, input logic lst);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im; last = lst;
  endtask

  task automatic do_start(input logic [9:0] base);
    base_addr = base;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_s = 1'b0; base_addr = '0; base_addr_s = '0;
    in_valid = 1'b0; in_valid_s = 1'b0;
    bundle(3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_we",    {31'd0, imem_we}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_addr",  {22'd0, imem_addr}, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_count", {21'd0, count}, 32'd0);

    // 1: single I word with last
    do_start(10'h010);
    check("t1_ready", {31'd0, in_ready}, 32'd1);
    check("t1_busy",  {31'd0, busy}, 32'd1);
    bundle(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t1_we",    {31'd0, imem_we}, 32'd1);
    check("t1_addr",  {22'd0, imem_addr}, 32'h010);
    check("t1_data",  imem_wdata, 32'h00500093);
    check("t1_count", {21'd0, count}, 32'd1);
    check("t1_ready_drain", {31'd0, in_ready}, 32'd0);
    check("t1_done_early",  {31'd0, done}, 32'd0);
    tick();
    check("t1_done",  {31'd0, done}, 32'd1);
    check("t1_we_done", {31'd0, imem_we}, 32'd0);
    tick();
    check("t1_done_off", {31'd0, done}, 32'd0);
    check("t1_idle",  {31'd0, busy}, 32'd0);

    // 2: S then SB
    do_start(10'h020);
    in_valid = 1'b1;
    bundle(3'b001, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 1'b0);
    tick();
    check("t2_s_addr", {22'd0, imem_addr}, 32'h020);
    check("t2_s_data", imem_wdata, 32'h0020A423);
    bundle(3'b010, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'hFFFFFFFC, 1'b1);
    tick();
    in_valid = 1'b0;
    check("t2_sb_we",   {31'd0, imem_we}, 32'd1);
    check("t2_sb_addr", {22'd0, imem_addr}, 32'h021);
    check("t2_sb_data", imem_wdata, 32'hFE208EE3);
    tick();
    check("t2_done", {31'd0, done}, 32'd1);
    tick();

    // 3: U, R, UJ, I back-to-back
    do_start(10'h100);
    in_valid = 1'b1;
    bundle(3'b011, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b0);
    tick();
    check("t3_u_addr", {22'd0, imem_addr}, 32'h100);
    check("t3_u_data", imem_wdata, 32'h123452B7);
    bundle(3'b100, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
    tick();
    check("t3_r_addr", {22'd0, imem_addr}, 32'h101);
    check("t3_r_data", imem_wdata, 32'h002081B3);
    bundle(3'b101, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b0);
    tick();
    check("t3_uj_we",   {31'd0, imem_we}, 32'd1);
    check("t3_uj_addr", {22'd0, imem_addr}, 32'h102);
    check("t3_uj_data", imem_wdata, 32'h008000EF);
    bundle(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
    tick();
    in_valid = 1'b0;
    check("t3_i_addr", {22'd0, imem_addr}, 32'h103);
    check("t3_count",  {21'd0, count}, 32'd4);
    tick();
    check("t3_done", {31'd0, done}, 32'd1);
    tick();

    // 4: legal, illegal, legal(last)
    do_start(10'h040);
    in_valid = 1'b1;
    bundle(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
    tick();
    check("t4_w0_addr", {22'd0, imem_addr}, 32'h040);
    bundle(3'b111, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
    tick();
    check("t4_ill_we",    {31'd0, imem_we}, 32'd0);
    check("t4_ill_error", {31'd0, error}, 32'd1);
    check("t4_ill_count", {21'd0, count}, 32'd1);
    check("t4_ill_ready", {31'd0, in_ready}, 32'd1);
    bundle(3'b001, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 1'b1);
    tick();
    in_valid = 1'b0;
    check("t4_w1_addr", {22'd0, imem_addr}, 32'h041);
    check("t4_w1_data", imem_wdata, 32'h0020A423);
    check("t4_count",   {21'd0, count}, 32'd2);
    tick(); tick();
    check("t4_error_sticky", {31'd0, error}, 32'd1);
    // illegal bundle carrying last still ends the load; start clears error
    do_start(10'h050);
    check("t4_error_clr", {31'd0, error}, 32'd0);
    in_valid = 1'b1;
    bundle(3'b110, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
    tick();
    in_valid = 1'b0;
    check("t4_ill_last_we",    {31'd0, imem_we}, 32'd0);
    check("t4_ill_last_ready", {31'd0, in_ready}, 32'd0);
    check("t4_ill_last_count", {21'd0, count}, 32'd0);
    tick();
    check("t4_ill_last_done", {31'd0, done}, 32'd1);
    tick();

    // 5: top-address stop on 4-bit instance
    base_addr_s = 4'hF;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    in_valid_s = 1'b1;
    bundle(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
    tick();
    check("t5_we",    {31'd0, imem_we_s}, 32'd1);
    check("t5_addr",  {28'd0, imem_addr_s}, 32'hF);
    check("t5_data",  imem_wdata_s, 32'h00500093);
    check("t5_ready", {31'd0, in_ready_s}, 32'd0);
    tick();
    in_valid_s = 1'b0;
    check("t5_we2",   {31'd0, imem_we_s}, 32'd0);
    check("t5_done",  {31'd0, done_s}, 32'd1);
    check("t5_count", {27'd0, count_s}, 32'd1);
    tick();
    check("t5_idle",  {31'd0, busy_s}, 32'd0);

    // 6: reset while a bundle is being accepted
    do_start(10'h200);
    in_valid = 1'b1;
    bundle(3'b011, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("t6_we",    {31'd0, imem_we}, 32'd0);
    check("t6_busy",  {31'd0, busy}, 32'd0);
    check("t6_count", {21'd0, count}, 32'd0);
    do_start(10'h300);
    in_valid = 1'b1;
    bundle(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
    tick();
    in_valid = 1'b0;
    check("t6_reload_addr", {22'd0, imem_addr}, 32'h300);
    check("t6_reload_data", imem_wdata, 32'h00500093);
    tick();
    check("t6_reload_done", {31'd0, done}, 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
